// File: rtl/obi_arb_pkg.sv
// Shared source-ID type and arbitration-mode constants for the OBI memory arbiter.
package obi_arb_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } arb_src_e;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    function automatic arb_src_e other_src(input arb_src_e s);
        return (s == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
    endfunction

endpackage

// File: rtl/obi_mem_arbiter_if.sv
// One OBI request/response channel; master drives the request, slave answers with gnt/rvalid/rdata.
interface obi_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted-transfer sources; the head tells which master owns the next response.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  arb_src_e src_i,
    input  logic     pop_i,
    output arb_src_e head_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    arb_src_e         ids_q [DEPTH];
    arb_src_e         ids_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            ids_d[wr_ptr_q] = src_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage carries no reset: only the pointers and count decide what is valid.
    always_ff @(posedge clk_i) begin
        ids_q <= ids_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = ids_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-port OBI memory between the instruction and data masters, routing
// each response back to its issuer in grant order.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ARB_MODE        = ARB_RR
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    obi_mem_arbiter_if.slave  instr_bus,
    obi_mem_arbiter_if.slave  data_bus,
    obi_mem_arbiter_if.master mem_bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic     en_q, en_d;
    logic     lock_q, lock_d;
    arb_src_e lock_src_q, lock_src_d;
    arb_src_e rr_q, rr_d;
    arb_src_e sel;
    arb_src_e head_src;
    logic     mem_req, granted, pop, fifo_full, fifo_empty;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // The instruction port is read-only; its write-side signals are intentionally ignored.
    logic unused_instr;
    assign unused_instr = ^{instr_bus.we, instr_bus.be, instr_bus.wdata};

    always_comb begin
        sel = rr_q;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (instr_bus.req && !data_bus.req) begin
            sel = SRC_INSTR;
        end else if (data_bus.req && !instr_bus.req) begin
            sel = SRC_DATA;
        end else if (ARB_MODE == ARB_FIXED) begin
            sel = SRC_DATA;
        end
    end

    always_comb begin
        sel_addr  = instr_bus.addr;
        sel_we    = 1'b0;
        sel_be    = '1;
        sel_wdata = '0;
        if (sel == SRC_DATA) begin
            sel_addr  = data_bus.addr;
            sel_we    = data_bus.we;
            sel_be    = data_bus.be;
            sel_wdata = data_bus.wdata;
        end
    end

    assign mem_req = en_q && (instr_bus.req || data_bus.req) && !fifo_full;
    assign granted = mem_req && mem_bus.gnt;
    assign pop     = mem_bus.rvalid && !fifo_empty;

    // An ungranted offer pins the selection so the memory sees a stable request.
    always_comb begin
        en_d       = 1'b1;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        rr_d       = rr_q;
        if (mem_req) begin
            lock_d     = !mem_bus.gnt;
            lock_src_d = sel;
        end
        if (granted) begin
            rr_d = other_src(sel);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            rr_q       <= SRC_INSTR;
        end else begin
            en_q       <= en_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            rr_q       <= rr_d;
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (granted),
        .src_i   (sel),
        .pop_i   (pop),
        .head_o  (head_src),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign mem_bus.req   = mem_req;
    assign mem_bus.addr  = sel_addr;
    assign mem_bus.we    = sel_we;
    assign mem_bus.be    = sel_be;
    assign mem_bus.wdata = sel_wdata;

    assign instr_bus.gnt    = granted && (sel == SRC_INSTR);
    assign data_bus.gnt     = granted && (sel == SRC_DATA);
    assign instr_bus.rvalid = pop && (head_src == SRC_INSTR);
    assign data_bus.rvalid  = pop && (head_src == SRC_DATA);
    assign instr_bus.rdata  = mem_bus.rdata;
    assign data_bus.rdata   = mem_bus.rdata;

    assert property (@(posedge clk_i) disable iff (!rst_ni) instr_bus.gnt |-> instr_bus.req);
    assert property (@(posedge clk_i) disable iff (!rst_ni) data_bus.gnt |-> data_bus.req);
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(instr_bus.gnt && data_bus.gnt));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (mem_req && !mem_bus.gnt) |=> $stable(mem_bus.addr));
    assert property (@(posedge clk_i) disable iff (!rst_ni) mem_bus.rvalid |-> !fifo_empty)
        else $warning("memory response with no outstanding transfer dropped");

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: vector table, hand sequences, and a randomized model comparison.
module tb_obi_mem_arbiter;
    import obi_arb_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXO = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i0 ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) d0 ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0 ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i1 ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) d1 ();
    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1 ();

    obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .ARB_MODE(ARB_RR))
        dut_rr (.clk_i(clk), .rst_ni(rst_n), .instr_bus(i0), .data_bus(d0), .mem_bus(m0));
    obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .ARB_MODE(ARB_FIXED))
        dut_fx (.clk_i(clk), .rst_ni(rst_n), .instr_bus(i1), .data_bus(d1), .mem_bus(m1));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ireq, dreq, gnt, rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ig, e_dg, e_irv, e_drv;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic ireq, dreq, gnt, rv, input logic [31:0] rdata,
                           input logic e_req, input logic [31:0] e_addr,
                           input logic e_ig, e_dg, e_irv, e_drv);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv; v.e_drv = e_drv;
        tbl.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic ireq, dreq, gnt, rv, input logic [31:0] rdata);
        i0.req = ireq; d0.req = dreq; m0.gnt = gnt; m0.rvalid = rv; m0.rdata = rdata;
    endtask

    task automatic expect0(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_ig, e_dg, e_irv, e_drv, input logic [31:0] e_rdata);
        check({tag, ".mem_req"}, 32'(m0.req), 32'(e_req));
        if (e_req) check({tag, ".mem_addr"}, m0.addr, e_addr);
        check({tag, ".instr_gnt"}, 32'(i0.gnt), 32'(e_ig));
        check({tag, ".data_gnt"}, 32'(d0.gnt), 32'(e_dg));
        check({tag, ".instr_rvalid"}, 32'(i0.rvalid), 32'(e_irv));
        check({tag, ".data_rvalid"}, 32'(d0.rvalid), 32'(e_drv));
        if (e_irv) check({tag, ".instr_rdata"}, i0.rdata, e_rdata);
        if (e_drv) check({tag, ".data_rdata"}, d0.rdata, e_rdata);
    endtask

    task automatic idle_all();
        i0.req = 0; i0.addr = 32'h180; i0.we = 0; i0.be = 4'h0; i0.wdata = '0;
        d0.req = 0; d0.addr = 32'h200; d0.we = 0; d0.be = 4'hF; d0.wdata = '0;
        m0.gnt = 0; m0.rvalid = 0; m0.rdata = '0;
        i1.req = 0; i1.addr = 32'h1C0; i1.we = 0; i1.be = 4'h0; i1.wdata = '0;
        d1.req = 0; d1.addr = 32'h300; d1.we = 1; d1.be = 4'b0011; d1.wdata = 32'hA5A5_0000;
        m1.gnt = 0; m1.rvalid = 0; m1.rdata = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 0;
        next_cycle();
        next_cycle();
        rst_n = 1;
        next_cycle();
    endtask

    // Reference model state for the randomized phase.
    arb_src_e    mq[$];
    arb_src_e    last_src, pend_src, src;
    bit          pend, ihold, dhold, e_req, e_ig, e_dg, e_irv, e_drv;
    logic [31:0] iaddr, daddr, dwdata, rdata;
    logic [3:0]  dbe;
    logic        dwe, gnt, rv;

    initial begin
        // Reset holds every output low even with both masters requesting.
        idle_all();
        rst_n = 0;
        i0.req = 1; d0.req = 1; m0.gnt = 1; m0.rvalid = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        expect0("rst", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        m0.gnt = 0; m0.rvalid = 0;
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        check("rel.mem_req_before_clk", 32'(m0.req), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rel.mem_req_first_clk", 32'(m0.req), 32'd1);
        check("rel.mem_addr_first_clk", m0.addr, 32'h180);
        next_cycle();

        // Round-robin alternation, then outstanding limit, then a lone instr transfer.
        add_vec(1, 1, 1, 0, 32'h0,    1, 32'h180, 1, 0, 0, 0);
        add_vec(1, 1, 1, 1, 32'h13,   1, 32'h200, 0, 1, 1, 0);
        add_vec(1, 1, 1, 1, 32'hCAFE, 1, 32'h180, 1, 0, 0, 1);
        add_vec(1, 1, 1, 1, 32'h13,   1, 32'h200, 0, 1, 1, 0);
        add_vec(0, 0, 0, 1, 32'hCAFE, 0, 32'h0,   0, 0, 0, 1);
        add_vec(1, 0, 1, 0, 32'h0,    1, 32'h180, 1, 0, 0, 0);
        add_vec(1, 0, 1, 0, 32'h0,    1, 32'h180, 1, 0, 0, 0);
        add_vec(1, 0, 1, 0, 32'h0,    0, 32'h0,   0, 0, 0, 0);
        add_vec(1, 0, 1, 1, 32'h13,   0, 32'h0,   0, 0, 1, 0);
        add_vec(1, 0, 1, 0, 32'h0,    1, 32'h180, 1, 0, 0, 0);
        add_vec(0, 0, 0, 1, 32'h13,   0, 32'h0,   0, 0, 1, 0);
        add_vec(0, 0, 0, 1, 32'h13,   0, 32'h0,   0, 0, 1, 0);
        add_vec(1, 0, 1, 0, 32'h0,    1, 32'h180, 1, 0, 0, 0);
        add_vec(0, 0, 0, 1, 32'h13,   0, 32'h0,   0, 0, 1, 0);
        foreach (tbl[k]) begin
            drive0(tbl[k].ireq, tbl[k].dreq, tbl[k].gnt, tbl[k].rv, tbl[k].rdata);
            @(negedge clk);
            expect0($sformatf("vec%0d", k), tbl[k].e_req, tbl[k].e_addr, tbl[k].e_ig,
                    tbl[k].e_dg, tbl[k].e_irv, tbl[k].e_drv, tbl[k].rdata);
            next_cycle();
        end

        // Lock: last grant was instr, so without the lock data would win in cycle 1.
        drive0(1, 0, 0, 0, '0);
        @(negedge clk); expect0("lock0", 1, 32'h180, 0, 0, 0, 0, '0); next_cycle();
        drive0(1, 1, 0, 0, '0);
        @(negedge clk); expect0("lock1", 1, 32'h180, 0, 0, 0, 0, '0); next_cycle();
        @(negedge clk); expect0("lock2", 1, 32'h180, 0, 0, 0, 0, '0); next_cycle();
        drive0(1, 1, 1, 0, '0);
        @(negedge clk); expect0("lock3", 1, 32'h180, 1, 0, 0, 0, '0); next_cycle();
        @(negedge clk); expect0("lock4", 1, 32'h200, 0, 1, 0, 0, '0); next_cycle();
        drive0(0, 0, 0, 1, 32'h13);
        @(negedge clk); expect0("lock5", 0, '0, 0, 0, 1, 0, 32'h13); next_cycle();
        drive0(0, 0, 0, 1, 32'hCAFE);
        @(negedge clk); expect0("lock6", 0, '0, 0, 0, 0, 1, 32'hCAFE); next_cycle();

        // Reset with two outstanding (data then instr), then a stray response.
        d0.addr = 32'h240;
        drive0(0, 1, 1, 0, '0);
        @(negedge clk); expect0("mid0", 1, 32'h240, 0, 1, 0, 0, '0); next_cycle();
        drive0(1, 0, 1, 0, '0);
        @(negedge clk); expect0("mid1", 1, 32'h180, 1, 0, 0, 0, '0); next_cycle();
        rst_n = 0;
        drive0(1, 1, 1, 1, 32'hDEAD);
        #1;
        expect0("mid_rst", 0, '0, 0, 0, 0, 0, '0);
        drive0(0, 0, 0, 0, '0);
        next_cycle();
        next_cycle();
        rst_n = 1;
        next_cycle();
        drive0(0, 0, 0, 1, 32'hBEEF);
        @(negedge clk); expect0("stray", 0, '0, 0, 0, 0, 0, '0); next_cycle();
        drive0(1, 1, 1, 0, '0);
        @(negedge clk); expect0("post_rst", 1, 32'h180, 1, 0, 0, 0, '0); next_cycle();
        drive0(0, 0, 0, 1, 32'h13);
        @(negedge clk); expect0("post_rsp", 0, '0, 0, 0, 1, 0, 32'h13); next_cycle();

        // Randomized traffic against the queue model; masters hold a request until granted.
        do_reset();
        mq.delete();
        last_src = SRC_DATA;
        pend = 0; pend_src = SRC_INSTR;
        ihold = 0; dhold = 0;
        iaddr = '0; daddr = '0; dwdata = '0; dbe = 4'hF; dwe = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ihold && $urandom_range(0, 2) != 0) begin
                ihold = 1; iaddr = {$urandom_range(0, 1023), 2'b00};
            end
            if (!dhold && $urandom_range(0, 2) != 0) begin
                dhold = 1; daddr = {$urandom_range(0, 1023), 2'b00};
                dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom_range(1, 15)); dwdata = $urandom;
            end
            gnt   = ($urandom_range(0, 3) != 0);
            rv    = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            rdata = $urandom;

            e_req = (ihold || dhold) && (mq.size() < MAXO);
            if (pend)               src = pend_src;
            else if (ihold && !dhold) src = SRC_INSTR;
            else if (dhold && !ihold) src = SRC_DATA;
            else                    src = (last_src == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
            e_ig  = e_req && gnt && (src == SRC_INSTR);
            e_dg  = e_req && gnt && (src == SRC_DATA);
            e_irv = rv && (mq[0] == SRC_INSTR);
            e_drv = rv && (mq[0] == SRC_DATA);

            i0.req = ihold; i0.addr = iaddr;
            d0.req = dhold; d0.addr = daddr; d0.we = dwe; d0.be = dbe; d0.wdata = dwdata;
            m0.gnt = gnt; m0.rvalid = rv; m0.rdata = rdata;
            @(negedge clk);
            expect0($sformatf("rnd%0d", n), e_req, (src == SRC_INSTR) ? iaddr : daddr,
                    e_ig, e_dg, e_irv, e_drv, rdata);
            if (e_req) begin
                check($sformatf("rnd%0d.we", n), 32'(m0.we), (src == SRC_DATA) ? 32'(dwe) : 32'd0);
                check($sformatf("rnd%0d.be", n), 32'(m0.be), (src == SRC_DATA) ? 32'(dbe) : 32'hF);
                if (src == SRC_DATA) check($sformatf("rnd%0d.wdata", n), m0.wdata, dwdata);
            end

            if (rv) void'(mq.pop_front());
            if (e_ig || e_dg) begin
                mq.push_back(src);
                last_src = src;
                pend = 0;
                if (src == SRC_INSTR) ihold = 0;
                else dhold = 0;
            end else if (e_req) begin
                pend = 1;
                pend_src = src;
            end
            next_cycle();
        end
        drive0(0, 0, 0, 0, '0);

        // Fixed priority: data wins every cycle while both request; writes pass through.
        for (int k = 0; k < 4; k++) begin
            i1.req = 1; d1.req = 1; m1.gnt = 1; m1.rvalid = (k > 0); m1.rdata = 32'hCAFE;
            @(negedge clk);
            check($sformatf("fix%0d.data_gnt", k), 32'(d1.gnt), 32'd1);
            check($sformatf("fix%0d.instr_gnt", k), 32'(i1.gnt), 32'd0);
            check($sformatf("fix%0d.we", k), 32'(m1.we), 32'd1);
            check($sformatf("fix%0d.be", k), 32'(m1.be), 32'b0011);
            check($sformatf("fix%0d.addr", k), m1.addr, 32'h300);
            check($sformatf("fix%0d.wdata", k), m1.wdata, 32'hA5A5_0000);
            check($sformatf("fix%0d.data_rvalid", k), 32'(d1.rvalid), 32'(k > 0));
            check($sformatf("fix%0d.instr_rvalid", k), 32'(i1.rvalid), 32'd0);
            next_cycle();
        end
        d1.req = 0; m1.rvalid = 1;
        @(negedge clk);
        check("fix4.instr_gnt", 32'(i1.gnt), 32'd1);
        check("fix4.we", 32'(m1.we), 32'd0);
        check("fix4.be", 32'(m1.be), 32'hF);
        check("fix4.addr", m1.addr, 32'h1C0);
        check("fix4.data_rvalid", 32'(d1.rvalid), 32'd1);
        next_cycle();
        i1.req = 0; m1.gnt = 0; m1.rdata = 32'h13;
        @(negedge clk);
        check("fix5.instr_rvalid", 32'(i1.rvalid), 32'd1);
        check("fix5.instr_rdata", i1.rdata, 32'h13);
        check("fix5.data_rvalid", 32'(d1.rvalid), 32'd0);
        next_cycle();
        m1.rvalid = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
